// File: rtl/img_rect_region_marker_pkg.sv
// img_rect_pkg: shared widths, rectangle parameter and stream flag types for the ROI marker
package img_rect_pkg;
  localparam int X_BITS_DEF = 11;
  localparam int Y_BITS_DEF = 10;
  localparam int DATA_BITS_DEF = 24;
  localparam int USER_BITS_DEF = 1;
  typedef struct packed {
    logic enable;
    logic [X_BITS_DEF-1:0] x;
    logic [Y_BITS_DEF-1:0] y;
    logic [X_BITS_DEF-1:0] width;
    logic [Y_BITS_DEF-1:0] height;
  } rect_param_t;
  typedef struct packed {
    logic row_first;
    logic row_last;
    logic col_first;
    logic col_last;
    logic de;
    logic valid;
  } flags_t;
endpackage

// File: rtl/img_rect_region_marker_if.sv
// img_rect_region_marker_if: pixel stream bundle (frame flags, de/valid, data, user)
interface img_rect_region_marker_if #(parameter int DATA_BITS = 24, parameter int USER_BITS = 1);
  logic row_first;
  logic row_last;
  logic col_first;
  logic col_last;
  logic de;
  logic valid;
  logic [DATA_BITS-1:0] data;
  logic [USER_BITS-1:0] user;
  modport master(output row_first, row_last, col_first, col_last, de, valid, data, user);
  modport slave(input row_first, row_last, col_first, col_last, de, valid, data, user);
endinterface

// File: rtl/img_rect_region_marker_param_shadow.sv
// img_rect_param_shadow: pending update flag and frame-start shadow load of the rectangle
// Optional IMG_RECT_UPDATE_INDEX_EN adds out_update_index, toggled on every shadow load.
module img_rect_param_shadow #(
  parameter int X_BITS = 11,
  parameter int Y_BITS = 10,
  parameter bit INIT_ENABLE = 1'b1,
  parameter logic [X_BITS-1:0] INIT_PARAM_X = '0,
  parameter logic [Y_BITS-1:0] INIT_PARAM_Y = '0,
  parameter logic [X_BITS-1:0] INIT_PARAM_WIDTH = '1,
  parameter logic [Y_BITS-1:0] INIT_PARAM_HEIGHT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic cke,
  input  logic in_update_req,
  input  logic s_valid,
  input  logic s_row_first,
  input  logic s_col_first,
  input  logic enable,
  input  logic [X_BITS-1:0] param_x,
  input  logic [Y_BITS-1:0] param_y,
  input  logic [X_BITS-1:0] param_width,
  input  logic [Y_BITS-1:0] param_height,
  output logic cur_enable,
  output logic [X_BITS-1:0] cur_x,
  output logic [Y_BITS-1:0] cur_y,
  output logic [X_BITS-1:0] cur_width,
  output logic [Y_BITS-1:0] cur_height,
`ifdef IMG_RECT_UPDATE_INDEX_EN
  output logic out_update_index,
`endif
  output logic out_busy
);
  logic pending, trig, load;
  logic sh_en;
  logic [X_BITS-1:0] sh_x, sh_w;
  logic [Y_BITS-1:0] sh_y, sh_h;
  assign trig = cke & s_valid & s_row_first & s_col_first;
  assign load = trig & pending;
  assign out_busy = pending;
  // the trigger pixel already sees the new values
  assign cur_enable = load ? enable : sh_en;
  assign cur_x = load ? param_x : sh_x;
  assign cur_y = load ? param_y : sh_y;
  assign cur_width = load ? param_width : sh_w;
  assign cur_height = load ? param_height : sh_h;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
      sh_en <= INIT_ENABLE;
      sh_x <= INIT_PARAM_X;
      sh_y <= INIT_PARAM_Y;
      sh_w <= INIT_PARAM_WIDTH;
      sh_h <= INIT_PARAM_HEIGHT;
    end else begin
      pending <= pending ? ~trig : in_update_req;
      if (load) begin
        sh_en <= enable;
        sh_x <= param_x;
        sh_y <= param_y;
        sh_w <= param_width;
        sh_h <= param_height;
      end
    end
  end
`ifdef IMG_RECT_UPDATE_INDEX_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_update_index <= 1'b0;
    else if (load) out_update_index <= ~out_update_index;
  end
`endif
endmodule

// File: rtl/img_rect_region_marker.sv
// img_rect_region_marker: x/y tracking, rectangle test and masked/cropped plus original output streams
// Optional IMG_RECT_UPDATE_INDEX_EN adds out_update_index.
module img_rect_region_marker
  import img_rect_pkg::*;
#(
  parameter int X_BITS = X_BITS_DEF,
  parameter int Y_BITS = Y_BITS_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int USER_BITS = USER_BITS_DEF,
  parameter int BYPASS_SIZE = 1,
  parameter bit INIT_ENABLE = 1'b1,
  parameter logic [X_BITS-1:0] INIT_PARAM_X = '0,
  parameter logic [Y_BITS-1:0] INIT_PARAM_Y = '0,
  parameter logic [X_BITS-1:0] INIT_PARAM_WIDTH = '1,
  parameter logic [Y_BITS-1:0] INIT_PARAM_HEIGHT = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic cke,
  input  logic in_update_req,
  input  logic enable,
  input  logic [X_BITS-1:0] param_x,
  input  logic [Y_BITS-1:0] param_y,
  input  logic [X_BITS-1:0] param_width,
  input  logic [Y_BITS-1:0] param_height,
  img_rect_region_marker_if.slave s,
  img_rect_region_marker_if.master m,
  img_rect_region_marker_if.master m_org,
  output logic m_org_region,
`ifdef IMG_RECT_UPDATE_INDEX_EN
  output logic out_update_index,
`endif
  output logic out_busy
);
  logic p_en;
  logic [X_BITS-1:0] p_x, p_w, cur_x, x_q;
  logic [Y_BITS-1:0] p_y, p_h, cur_y, y_q;
  logic [X_BITS:0] x_end, x_last;
  logic [Y_BITS:0] y_end, y_last;
  logic in_region;
  flags_t f_in, f_byp, f_crop, m_nx, m_q, o_q;
  logic [DATA_BITS-1:0] d_q;
  logic [USER_BITS-1:0] u_q;
  img_rect_param_shadow #(
    .X_BITS(X_BITS), .Y_BITS(Y_BITS), .INIT_ENABLE(INIT_ENABLE),
    .INIT_PARAM_X(INIT_PARAM_X), .INIT_PARAM_Y(INIT_PARAM_Y),
    .INIT_PARAM_WIDTH(INIT_PARAM_WIDTH), .INIT_PARAM_HEIGHT(INIT_PARAM_HEIGHT)
  ) u_shadow (
    .clk(clk), .reset(reset), .cke(cke), .in_update_req(in_update_req),
    .s_valid(s.valid), .s_row_first(s.row_first), .s_col_first(s.col_first),
    .enable(enable), .param_x(param_x), .param_y(param_y),
    .param_width(param_width), .param_height(param_height),
    .cur_enable(p_en), .cur_x(p_x), .cur_y(p_y), .cur_width(p_w), .cur_height(p_h),
`ifdef IMG_RECT_UPDATE_INDEX_EN
    .out_update_index(out_update_index),
`endif
    .out_busy(out_busy)
  );
  assign cur_x = s.col_first ? '0 : x_q + 1'b1;
  assign cur_y = (s.row_first & s.col_first) ? '0 : s.col_first ? y_q + 1'b1 : y_q;
  // one extra bit so the rectangle end never wraps back into the frame
  assign x_end = {1'b0, p_x} + {1'b0, p_w};
  assign y_end = {1'b0, p_y} + {1'b0, p_h};
  assign x_last = x_end - 1'b1;
  assign y_last = y_end - 1'b1;
  assign in_region = (cur_x >= p_x) & ({1'b0, cur_x} < x_end) & (cur_y >= p_y) & ({1'b0, cur_y} < y_end);
  assign f_in = {s.row_first, s.row_last, s.col_first, s.col_last, s.de, s.valid};
  assign f_byp = {s.row_first, s.row_last, s.col_first, s.col_last, s.de & in_region, s.valid};
  assign f_crop = {cur_y == p_y, ({1'b0, cur_y} == y_last) | s.row_last,
                   cur_x == p_x, ({1'b0, cur_x} == x_last) | s.col_last,
                   s.de, s.valid & in_region};
  assign m_nx = !p_en ? f_in : (BYPASS_SIZE != 0) ? f_byp : f_crop;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
      m_q <= '0;
      o_q <= '0;
      d_q <= '0;
      u_q <= '0;
      m_org_region <= 1'b0;
    end else if (cke) begin
      if (s.valid) begin
        x_q <= cur_x;
        y_q <= cur_y;
      end
      m_q <= m_nx;
      o_q <= f_in;
      d_q <= s.data;
      u_q <= s.user;
      m_org_region <= in_region;
    end
  end
  assign {m.row_first, m.row_last, m.col_first, m.col_last, m.de, m.valid} = m_q;
  assign {m_org.row_first, m_org.row_last, m_org.col_first, m_org.col_last, m_org.de, m_org.valid} = o_q;
  assign m.data = d_q;
  assign m.user = u_q;
  assign m_org.data = d_q;
  assign m_org.user = u_q;
endmodule

// File: tb/tb_img_rect_region_marker.sv
// tb_img_rect_region_marker: directed 8x6 frames on a bypass and a crop instance sharing one input stream
module tb_img_rect_region_marker;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cke = 1'b1;
  logic in_update_req = 1'b0;
  logic enable = 1'b1;
  logic [10:0] param_x = '0, param_width = '1;
  logic [9:0] param_y = '0, param_height = '1;
  logic rb, rc, busy_b, busy_c;
`ifdef IMG_RECT_UPDATE_INDEX_EN
  logic idx_b, idx_c;
`endif
  int n_assert = 0, n_fail = 0;
  int fid = 0, cnt_v, cnt_de;
  int rx, ry, rw, rh, nx, ny, nw, nh, ux, uy, uw, uh;
  bit ren, nen, npend, uen;
  img_rect_region_marker_if #(.DATA_BITS(24), .USER_BITS(1)) s(), mb(), ob(), mc(), oc();
  always #5 clk = ~clk;
  img_rect_region_marker #(.BYPASS_SIZE(1)) dut_b (
    .clk(clk), .reset(reset), .cke(cke), .in_update_req(in_update_req), .enable(enable),
    .param_x(param_x), .param_y(param_y), .param_width(param_width), .param_height(param_height),
    .s(s), .m(mb), .m_org(ob), .m_org_region(rb),
`ifdef IMG_RECT_UPDATE_INDEX_EN
    .out_update_index(idx_b),
`endif
    .out_busy(busy_b));
  img_rect_region_marker #(.BYPASS_SIZE(0)) dut_c (
    .clk(clk), .reset(reset), .cke(cke), .in_update_req(in_update_req), .enable(enable),
    .param_x(param_x), .param_y(param_y), .param_width(param_width), .param_height(param_height),
    .s(s), .m(mc), .m_org(oc), .m_org_region(rc),
`ifdef IMG_RECT_UPDATE_INDEX_EN
    .out_update_index(idx_c),
`endif
    .out_busy(busy_c));

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] dat(int x, int y);
    return 24'(((fid % 256) << 16) | (y << 8) | x);
  endfunction

  task automatic set_params(bit e, int x, int y, int w, int h);
    enable = e; param_x = 11'(x); param_y = 10'(y); param_width = 11'(w); param_height = 10'(h);
    nen = e; nx = x; ny = y; nw = w; nh = h;
  endtask

  task automatic request();
    s.valid = 1'b0;
    in_update_req = 1'b1;
    @(posedge clk); #1;
    in_update_req = 1'b0;
    npend = 1'b1;
    chk("busy_set", {busy_b, busy_c}, 2'b11);
  endtask

  task automatic apply_pending();
    if (npend) begin
      ren = nen; rx = nx; ry = ny; rw = nw; rh = nh; npend = 1'b0;
    end
  endtask

  task automatic check(int x, int y, bit de);
    bit rg;
    logic [5:0] fl, eb, ec;
    rg = x >= rx && x < rx + rw && y >= ry && y < ry + rh;
    fl = {y == 0, y == 5, x == 0, x == 7, de, 1'b1};
    eb = ren ? {fl[5:2], de & rg, 1'b1} : fl;
    ec = ren ? {y == ry, (y == ry + rh - 1) || y == 5, x == rx, (x == rx + rw - 1) || x == 7, de, rg} : fl;
    chk("org_b", {ob.row_first, ob.row_last, ob.col_first, ob.col_last, ob.de, ob.valid, ob.data, ob.user, rb},
        {fl, dat(x, y), 1'(x), rg});
    chk("org_c", {oc.row_first, oc.row_last, oc.col_first, oc.col_last, oc.de, oc.valid, oc.data, oc.user, rc},
        {fl, dat(x, y), 1'(x), rg});
    chk("bypass", {mb.row_first, mb.row_last, mb.col_first, mb.col_last, mb.de, mb.valid, mb.data, mb.user},
        {eb, dat(x, y), 1'(x)});
    chk("crop", {mc.row_first, mc.row_last, mc.col_first, mc.col_last, mc.de, mc.valid, mc.data, mc.user},
        {ec, dat(x, y), 1'(x)});
  endtask

  task automatic pix(int x, int y, bit de, bit upd);
    cke = 1'b1;
    s.valid = 1'b1; s.row_first = (y == 0); s.row_last = (y == 5);
    s.col_first = (x == 0); s.col_last = (x == 7); s.de = de;
    s.data = dat(x, y); s.user = 1'(x);
    in_update_req = upd;
    @(posedge clk); #1;
    in_update_req = 1'b0;
    check(x, y, de);
    cnt_v += int'(mc.valid);
    cnt_de += int'(mb.de);
  endtask

  task automatic frame(bit depat, int upd_at, bit rnd_cke, int ev, int ed);
    apply_pending();
    fid++;
    cnt_v = 0; cnt_de = 0;
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        bit de;
        de = depat ? (x != 3) : 1'b1;
        if (y * 8 + x == upd_at) begin
          set_params(uen, ux, uy, uw, uh);
          npend = 1'b1;
        end
        pix(x, y, de, y * 8 + x == upd_at);
        if (rnd_cke)
          repeat ($urandom_range(0, 2)) begin
            cke = 1'b0;
            s.valid = 1'(($urandom));
            s.row_first = 1'b1; s.col_first = 1'b1; s.de = 1'(($urandom));
            s.data = 24'($urandom);
            @(posedge clk); #1;
            check(x, y, de);
          end
      end
    cke = 1'b1;
    s.valid = 1'b0;
    @(posedge clk); #1;
    chk("valid_cnt", 64'(cnt_v), 64'(ev));
    chk("de_cnt", 64'(cnt_de), 64'(ed));
  endtask

  initial begin
    ren = 1'b1; rx = 0; ry = 0; rw = 2047; rh = 1023; npend = 1'b0;
    s.valid = 1'b0; s.row_first = 1'b0; s.row_last = 1'b0; s.col_first = 1'b0;
    s.col_last = 1'b0; s.de = 1'b0; s.data = '0; s.user = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byp", {mb.row_first, mb.row_last, mb.col_first, mb.col_last, mb.de, mb.valid, mb.data, mb.user}, '0);
    chk("rst_crop", {mc.row_first, mc.row_last, mc.col_first, mc.col_last, mc.de, mc.valid, mc.data, mc.user}, '0);
    chk("rst_org", {ob.row_first, ob.row_last, ob.col_first, ob.col_last, ob.de, ob.valid, ob.data, ob.user, rb}, '0);
    chk("rst_busy", {busy_b, busy_c, rc}, '0);
    reset = 1'b0;
    frame(0, -1, 0, 48, 48);
    set_params(1, 2, 1, 3, 2); request();
    frame(0, -1, 0, 6, 6);
    set_params(1, 6, 4, 5, 5); request();
    frame(0, -1, 0, 4, 4);
    set_params(1, 0, 0, 0, 0); request();
    frame(0, -1, 0, 0, 0);
    set_params(1, 2, 1, 3, 2); request();
    uen = 1'b1; ux = 0; uy = 0; uw = 2; uh = 2;
    frame(0, 20, 0, 6, 6);
    chk("busy_held", {busy_b, busy_c}, 2'b11);
    frame(0, -1, 0, 4, 4);
    chk("busy_clear", {busy_b, busy_c}, 2'b00);
    set_params(0, 2, 1, 3, 2); request();
    frame(1, -1, 0, 48, 42);
    set_params(1, 2, 1, 3, 2); request();
    frame(0, -1, 1, 6, 6);
    set_params(1, 1, 1, 1, 1); request();
    apply_pending();
    fid++;
    for (int i = 0; i < 10; i++) pix(i % 8, i / 8, 1'b1, 1'b0);
    set_params(1, 3, 3, 1, 1); request();
    reset = 1'b1;
    #1;
    chk("amid_byp", {mb.row_first, mb.row_last, mb.col_first, mb.col_last, mb.de, mb.valid, mb.data}, '0);
    chk("amid_crop", {mc.row_first, mc.row_last, mc.col_first, mc.col_last, mc.de, mc.valid, mc.data}, '0);
    chk("amid_busy", {busy_b, busy_c, rb, rc}, '0);
    @(negedge clk);
    reset = 1'b0;
    ren = 1'b1; rx = 0; ry = 0; rw = 2047; rh = 1023; npend = 1'b0;
    frame(0, -1, 0, 48, 48);
    chk("busy_final", {busy_b, busy_c}, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/img_rect_region_marker.md
Name: img_rect_region_marker

Overview:
- Streaming image-region (ROI) rectangle marker that sits inline in the pixel pipeline after the sensor/format stage and before consumers that need an ROI.
- Tracks the x/y position of every valid pixel and flags pixels inside a programmable rectangle.
- Emits a masked or cropped stream plus an aligned copy of the original stream.
- Rectangle parameters are shadowed and take effect only at frame start after an update request.

Parameters:
- X_BITS, 11, column coordinate width
- Y_BITS, 10, row coordinate width
- DATA_BITS, 24, pixel data width
- USER_BITS, 1, sideband user width
- BYPASS_SIZE, 1, 1 = keep full frame size and mask de; 0 = crop (valid and frame flags regenerated for the rectangle)
- INIT_ENABLE, 1, reset value of the enable shadow register
- INIT_PARAM_X, 0, reset rectangle left
- INIT_PARAM_Y, 0, reset rectangle top
- INIT_PARAM_WIDTH, all ones, reset rectangle width
- INIT_PARAM_HEIGHT, all ones, reset rectangle height

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cke  in  1  clock enable; all pipeline state holds when low
- in_update_req  in  1  request to load the parameter inputs at the next frame start
- enable, param_x, param_y, param_width, param_height  in  1/X/Y/X/Y  requested settings
- s_row_first, s_row_last, s_col_first, s_col_last, s_de, s_valid  in  1 each  input stream flags
- s_data  in  DATA_BITS  input pixel data
- s_user  in  USER_BITS  input sideband
- m_row_first, m_row_last, m_col_first, m_col_last, m_de, m_valid, m_data, m_user  out  as inputs  processed stream
- m_org_row_first ... m_org_user, m_org_region  out  as inputs, +1  original stream, aligned, plus in-region flag
- out_busy  out  1  update request pending

Behaviour:
- Reset: all outputs and flags are 0, data is 0, the pending flag is 0, and the shadows take their INIT_* values.
- Pending flag:
  - Set by in_update_req on any cycle, independent of cke.
  - A request arriving while the flag is already pending is absorbed.
- Frame-start trigger: s_valid & s_row_first & s_col_first & cke.
  - If the pending flag was set before this cycle, the shadows load enable/param_* and the flag clears.
  - A request arriving in the same cycle as a trigger with no pending flag is applied at the next frame.
- The trigger pixel itself uses the newly loaded values; the datapath muxes the new parameters for that pixel.
- Position counters, advanced on each s_valid & cke:
  - x = 0 on s_col_first, else the previous x + 1.
  - y = 0 at frame start; y increments on the first pixel of each subsequent row.
- Region test: in_region = (x >= px) & (x < px + pw) & (y >= py) & (y < py + ph).
  - Sums are computed with one extra bit, so the rectangle never wraps.
  - Width or height 0 gives an empty region.
- Latency: 1 registered cycle (cke-qualified) for both the m_ and m_org_ streams.
- enable = 0: the m_ stream is a bit-exact delayed copy of the input.
- enable = 1, BYPASS_SIZE = 1: m_de = s_de & in_region; all other signals pass through unchanged.
- enable = 1, BYPASS_SIZE = 0:
  - m_valid = s_valid & in_region.
  - m_row_first = (y == py); m_col_first = (x == px).
  - m_row_last = (y == py + ph - 1) | s_row_last; m_col_last = (x == px + pw - 1) | s_col_last, so a rectangle exceeding the frame is truncated at the frame edge.
- m_org_region carries in_region regardless of enable.
- cke low: registers, counters and shadows hold; the input is ignored.
- Reset mid-frame: state returns to reset values immediately; counting restarts at the next s_col_first.

Optional Feature:
- Macro: IMG_RECT_UPDATE_INDEX_EN.
- Defined: adds output out_update_index (1 bit, reset 0), which toggles on every shadow load so a register-side master can detect completion.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package img_rect_pkg holds:
  - default widths;
  - a packed struct rect_param_t {enable, x, y, width, height};
  - the stream flag struct.
- Natural sub-module: img_rect_param_shadow, covering the pending flag, trigger detect, shadow load and the optional index toggle.
- The top module holds the counters, comparators and output registers.

Test Plan:
- Reset: all m_/m_org_ outputs are 0; after release, an 8x6 frame with enable = 1 and the INIT rectangle gives m_de == s_de for every pixel.
- BYPASS_SIZE = 1, rect (2,1,3,2) on an 8x6 frame: m_de is high only for x in 2..4, y in 1..2 (6 pixels); valid count stays 48.
- BYPASS_SIZE = 0, same rect: exactly 6 m_valid pixels; the first has row_first & col_first, the last has row_last & col_last.
- Rect (6,4,5,5) on 8x6: crop is truncated to 2x2 with m_col_last at x = 7 and m_row_last at y = 5; width 0 gives zero m_valid.
- Pulse in_update_req mid-frame with new params: the current frame is unchanged, the next frame uses the new rect; out_busy stays high until that frame start.
- cke toggled randomly during a frame: the output matches the cke = 1 reference run.
